// File: rtl/cpu_feeder_pkg.sv
// Shared types and constants for the CPU instruction feeder: state encoding,
// opcode field width and the default halt opcode.
package cpu_feeder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } feeder_state_e;

    localparam int              OPC_W            = 4;
    localparam logic [OPC_W-1:0] HALT_OPC_DEFAULT = 4'hC;

endpackage

// File: rtl/cpu_ins_feeder_phase.sv
// CPU phase strobe generator: en2 pulses for one cycle after the divider
// counter reaches PHASE_DIV-1; counting only advances while en is high.
module phase_strobe_gen #(
    parameter int PHASE_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic en2
);

    localparam int               CNT_W   = $clog2(PHASE_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PHASE_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             en2_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= '0;
            en2_q <= 1'b0;
        end else if (en) begin
            en2_q <= (cnt_q == CNT_MAX);
            cnt_q <= (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
        end else begin
            // paused: count frozen, no strobe
            en2_q <= 1'b0;
        end
    end

    assign en2 = en2_q;

endmodule

// File: rtl/cpu_ins_feeder.sv
// Loadable program store feeding a 16-bit CPU on fetch requests, with halt
// opcode detection, loop mode and a phase strobe. Optional fetch counter
// port enabled by macro CPU_FEEDER_FETCH_CNT_EN.
module cpu_ins_feeder
    import cpu_feeder_pkg::*;
#(
    parameter int               DATA_W    = 16,
    parameter int               DEPTH     = 16,
    parameter int               ADDR_W    = $clog2(DEPTH),
    parameter int               PHASE_DIV = 2,
    parameter logic [OPC_W-1:0] HALT_OPC  = HALT_OPC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_in,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              start,
    input  logic              loop_mode,
    input  logic              en_fetch,
    output logic [DATA_W-1:0] ins,
    output logic              ins_valid,
    output logic              en2,
    output logic [ADDR_W-1:0] pc_out,
    output logic              halted,
    output logic              load_err
`ifdef CPU_FEEDER_FETCH_CNT_EN
    ,
    output logic [15:0]       fetch_cnt
`endif
);

    feeder_state_e     state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [DATA_W-1:0] ins_q, ins_d;
    logic              ins_valid_q, ins_valid_d;
    logic              halted_q, halted_d;
    logic              load_err_q, load_err_d;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_word_q;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W:0]   load_end;

    logic load_ok, fetch_ok, start_ok, is_halt_word;

    assign load_ok      = load_en && (state_q != ST_RUN);
    assign fetch_ok     = (state_q == ST_RUN) && en_in && en_fetch;
    assign start_ok     = start && (state_q != ST_RUN);
    assign is_halt_word = (rd_word_q[DATA_W-1 -: OPC_W] == HALT_OPC);
    assign load_end     = {1'b0, load_addr} + (ADDR_W+1)'(1);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        len_d       = len_q;
        ins_d       = ins_q;
        ins_valid_d = ins_valid_q;
        load_err_d  = load_en && (state_q == ST_RUN);

        // the load lands before a simultaneous start sees the length
        if (load_ok && (load_end > len_q)) begin
            len_d = load_end;
        end

        if (start_ok) begin
            pc_d        = '0;
            ins_valid_d = 1'b0;
            state_d     = (len_d == '0) ? ST_HALT : ST_RUN;
        end else if (fetch_ok) begin
            ins_d       = rd_word_q;
            ins_valid_d = 1'b1;
            if (is_halt_word) begin
                state_d = ST_HALT;
            end else if ({1'b0, pc_q} == len_q - 1'b1) begin
                if (loop_mode) begin
                    pc_d = '0;
                end else begin
                    state_d = ST_HALT;
                end
            end else begin
                pc_d = pc_q + 1'b1;
            end
        end

        halted_d = (state_d == ST_HALT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pc_q        <= '0;
            len_q       <= '0;
            ins_q       <= '0;
            ins_valid_q <= 1'b0;
            halted_q    <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            len_q       <= len_d;
            ins_q       <= ins_d;
            ins_valid_q <= ins_valid_d;
            halted_q    <= halted_d;
            load_err_q  <= load_err_d;
        end
    end

    // Registered read addressed by the next pc, so rd_word_q always mirrors
    // mem[pc_q]; a same-edge write to that address is forwarded.
    assign rd_addr = rst ? '0 : pc_d;

    always_ff @(posedge clk) begin
        if (load_ok) begin
            mem[load_addr] <= load_data;
        end
        rd_word_q <= (load_ok && (load_addr == rd_addr)) ? load_data : mem[rd_addr];
    end

    phase_strobe_gen #(
        .PHASE_DIV (PHASE_DIV)
    ) u_phase (
        .clk (clk),
        .rst (rst),
        .clr (start_ok),
        .en  ((state_q == ST_RUN) && en_in),
        .en2 (en2)
    );

`ifdef CPU_FEEDER_FETCH_CNT_EN
    logic [15:0] fetch_cnt_q;

    always_ff @(posedge clk) begin
        if (rst || start) begin
            fetch_cnt_q <= '0;
        end else if (fetch_ok && (fetch_cnt_q != 16'hFFFF)) begin
            fetch_cnt_q <= fetch_cnt_q + 16'd1;
        end
    end

    assign fetch_cnt = fetch_cnt_q;
`endif

    assign ins       = ins_q;
    assign ins_valid = ins_valid_q;
    assign pc_out    = pc_q;
    assign halted    = halted_q;
    assign load_err  = load_err_q;

endmodule

// File: doc/cpu_ins_feeder.md
# cpu_ins_feeder

Parametrised instruction feeder that sits between the program-load path and the 16-bit CPU's fetch port. It replaces the fixed, time-scripted instruction sequence and the hand-built `en2` phase strobe with a loadable program store and a fetch-driven handshake. It also adds halt-opcode detection and an optional looping mode. It drives `ins` and `en2` into `cpu` and consumes the CPU's `en_fetch` request.

## Interface
- `DATA_W`, default 16: instruction width.
- `DEPTH`, default 16: program store depth in words (power of two, ≥2).
- `ADDR_W`, default $clog2(DEPTH): program address width.
- `PHASE_DIV`, default 2: `en2` pulses once every `PHASE_DIV` enabled cycles (≥2).
- `HALT_OPC`, default 4'hC: value of `ins[DATA_W-1 -: 4]` that marks a halt instruction.
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `en_in` in 1: global run enable; low pauses the feeder.
- `load_en` in 1: write strobe for the program store.
- `load_addr` in ADDR_W: write address.
- `load_data` in DATA_W: write data.
- `start` in 1: begin execution from address 0.
- `loop_mode` in 1: at end of program, wrap to 0 instead of halting.
- `en_fetch` in 1: CPU request for the next instruction.
- `ins` out DATA_W: current instruction word to the CPU.
- `ins_valid` out 1: `ins` holds a fetched word.
- `en2` out 1: one-cycle CPU phase strobe.
- `pc_out` out ADDR_W: address of the next word to be fetched.
- `halted` out 1: feeder is in the HALT state.
- `load_err` out 1: one-cycle pulse when a load is attempted in RUN.

## Operation
- States are IDLE, RUN and HALT. Reset enters IDLE.
- **Loading**
  - A load is accepted in IDLE or HALT only: `mem[load_addr] <= load_data`.
  - The program length `len` is updated to max(`len`, `load_addr`+1).
- **IDLE/HALT → RUN**
  - `start` moves IDLE or HALT to RUN, with `pc_out` set to 0 and `ins_valid` cleared.
  - If `len` is 0 when `start` is asserted, the feeder goes straight to HALT.
- **Fetching in RUN** (requires `en_in`=1)
  - On `en_fetch`: `ins <= mem[pc_out]`, `ins_valid <= 1`.
  - If the fetched word's top 4 bits equal `HALT_OPC`, the next state is HALT. The halt word itself is still presented on `ins`.
  - Otherwise, if `pc_out` equals `len`-1: with `loop_mode`=1, `pc_out` wraps to 0; with `loop_mode`=0, the next state is HALT.
  - Otherwise `pc_out` increments.
  - When the halt opcode and end-of-program occur on the same fetch, the halt opcode wins and `pc_out` is not wrapped.
- **Phase divider**
  - A counter runs 0..`PHASE_DIV`-1 only while in RUN with `en_in`=1.
  - `en2` is 1 for the cycle after the counter equals `PHASE_DIV`-1.
  - The counter clears on entry to RUN.
- **Pause and ignored inputs**
  - With `en_in`=0: the divider freezes, `en2` is 0, and `en_fetch` is ignored.
  - Outside RUN, `en_fetch` is ignored.
- **Outputs across states**
  - In HALT, `ins` and `ins_valid` hold their last values.
  - `start` and `load_en` asserted together: the load is accepted and takes effect before the start.
- **Load during RUN**
  - The load is dropped and `load_err` pulses for 1 cycle.

## Timing
- **Reset values:** `ins`=0, `ins_valid`=0, `en2`=0, `pc_out`=0, `halted`=0, `load_err`=0, `len`=0, divider=0. Memory contents are not reset.
- **Reset mid-run:** the feeder returns to IDLE on the next edge and all registers take their reset values.
- **Fetch latency:** `en_fetch` sampled at edge N gives `ins` and `pc_out` updated after edge N.
- **Back-to-back fetches:** `en_fetch` held high fetches one word per cycle.
- **Halt timing:** `halted` rises on the edge after the fetch that triggers halt.
- **First strobe:** the first `en2` pulse comes `PHASE_DIV` cycles after entry to RUN with `en_in` high.

## Configuration
- Macro `CPU_FEEDER_FETCH_CNT_EN`.
- **Defined:**
  - Adds a 16-bit output port `fetch_cnt` that counts accepted fetches.
  - `fetch_cnt` clears on `rst` and on `start`, and saturates at 16'hFFFF.
- **Undefined:** the port and its counter are absent; all other behaviour is identical.

## Structure
- Shared package `cpu_feeder_pkg` holds:
  - the state enum (IDLE/RUN/HALT);
  - the default `HALT_OPC`;
  - the opcode field width constant (4).
- One sub-module, `phase_strobe_gen`: the `PHASE_DIV` counter and `en2` output, with inputs `clk`, `rst`, `clr`, `en`.

## Test plan
- **Load and fetch:** load 16'h0401, 16'h2402, 16'h2404 at addresses 0–2, then `start`, then three `en_fetch` pulses → `ins` = 0401, 2402, 2404 each one cycle after its pulse. `halted`=1 after the third, since `len`=3 and `loop_mode`=0.
- **Halt opcode:** load 0401, C400, 2402, then `start`, then fetch ×3 → `ins`=C400 is presented and `halted`=1. The third fetch is ignored and `ins` stays C400.
- **Loop mode:** `loop_mode`=1 with `len`=2 (words 0401, 2402), then 5 fetches → `ins` sequence 0401, 2402, 0401, 2402, 0401; `pc_out` returns to 0.
- **Phase strobe and pause:** `PHASE_DIV`=2, in RUN → `en2` pulses every 2nd cycle. Drop `en_in` for 3 cycles → no `en2` and fetches ignored. The pulse cadence resumes from the frozen count.
- **Load error and reset:** `load_en` during RUN → `load_err` 1-cycle pulse and memory unchanged. `rst` mid-run → all outputs read 0 on the next cycle, then `start` with `len`=0 → HALT immediately.
- **Fetch counter:** with `CPU_FEEDER_FETCH_CNT_EN` defined, 4 accepted fetches → `fetch_cnt`=4, then `start` → 0.
